// File: rtl/br_resolve_pkg.sv
// rtl/br_resolve_pkg.sv - shared types for branch resolution and predictor training
package types;

    localparam int GSHARE_IDX_W = 10;

    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    typedef struct packed {
        logic [31:0]             pc;
        logic [31:0]             inst;
        logic [31:0]             target_pc;
        logic [GSHARE_IDX_W-1:0] gshare_index;
        logic [1:0]              gshare_state;
        logic                    tournament_pred;
        logic                    valid;
    } br_pred_t;

    typedef struct packed {
        br_pred_t rec;
        logic     actual;
    } br_train_t;

    typedef enum logic [1:0] {
        IDLE,
        FLUSH,
        HOLD
    } br_res_state_e;

endpackage

// File: rtl/br_resolve_train_fifo.sv
// rtl/br_resolve_train_fifo.sv - synchronous FIFO of predictor training records
module train_fifo
    import types::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  br_train_t push_data,
    input  logic      pop,
    output br_train_t pop_data,
    output logic      full,
    output logic      empty
);

    localparam int AW = $clog2(DEPTH);

    br_train_t       mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count;
    logic            do_push;
    logic            do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Mask the head when empty so the output is a clean zero out of reset.
    assign pop_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/br_resolve.sv
// rtl/br_resolve.sv - commit-side branch resolution, mispredict flush and predictor training
module br_resolve
    import types::*;
#(
    parameter int TQ_DEPTH   = 4,
    parameter int FLUSH_HOLD = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        commit_valid,
    output logic        commit_ready,
    input  br_pred_t    commit_pred,
    input  logic        commit_taken,
    input  logic [31:0] commit_target,
    output logic        flush,
    output logic [31:0] redirect_pc,
    output logic        wb_en,
    output br_pred_t    write_back,
    output logic        actual,
    output logic [31:0] num_br,
    output logic [31:0] num_mispred
);

    localparam int HW = (FLUSH_HOLD > 1) ? $clog2(FLUSH_HOLD) : 1;

    br_res_state_e state;
    br_res_state_e state_next;
    logic [HW-1:0] hold_cnt;
    logic [HW-1:0] hold_cnt_next;

    logic [6:0]  op;
    logic        is_br;
    logic        is_jal;
    logic        pred_taken;
    logic        mispred;
    logic        accept;
    logic        tq_full;
    logic        tq_empty;
    br_train_t   tq_in;
    br_train_t   tq_out;

    assign op         = commit_pred.inst[6:0];
    assign is_br      = (op == OP_BR);
    assign is_jal     = (op == OP_JAL);
    assign pred_taken = commit_pred.valid && ((commit_pred.tournament_pred && is_br) || is_jal);
    assign mispred    = (pred_taken != commit_taken)
                     || (commit_taken && (commit_pred.target_pc != commit_target));

    assign commit_ready = (state == IDLE) && !tq_full;
    assign accept       = commit_valid && commit_ready;
    assign flush        = (state == FLUSH);

    always_comb begin
        state_next    = state;
        hold_cnt_next = hold_cnt;
        case (state)
            IDLE: begin
                if (accept && mispred) begin
                    state_next = FLUSH;
                end
            end
            FLUSH: begin
                state_next    = HOLD;
                hold_cnt_next = HW'(FLUSH_HOLD - 1);
            end
            HOLD: begin
                if (hold_cnt == '0) begin
                    state_next = IDLE;
                end else begin
                    hold_cnt_next = hold_cnt - HW'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            hold_cnt    <= '0;
            redirect_pc <= '0;
            num_br      <= '0;
            num_mispred <= '0;
        end else begin
            state    <= state_next;
            hold_cnt <= hold_cnt_next;
            if (accept) begin
                num_br <= num_br + 32'd1;
                if (mispred) begin
                    num_mispred <= num_mispred + 32'd1;
                    redirect_pc <= commit_taken ? commit_target : commit_pred.pc + 32'd4;
                end
            end
        end
    end

    // JAL targets are static, so only conditional branches train the predictor.
    assign tq_in.rec    = commit_pred;
    assign tq_in.actual = commit_taken;

    train_fifo #(
        .DEPTH(TQ_DEPTH)
    ) u_train_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (accept && is_br),
        .push_data (tq_in),
        .pop       (!tq_empty),
        .pop_data  (tq_out),
        .full      (tq_full),
        .empty     (tq_empty)
    );

    assign wb_en      = !tq_empty;
    assign write_back = tq_out.rec;
    assign actual     = tq_out.actual;

endmodule

// File: tb/tb_br_resolve.sv
// tb/tb_br_resolve.sv - self-checking bench for br_resolve against a behavioural model
module tb_br_resolve;
    import types::*;

    localparam int TQ_DEPTH   = 4;
    localparam int FLUSH_HOLD = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        commit_valid;
    logic        commit_ready;
    br_pred_t    commit_pred;
    logic        commit_taken;
    logic [31:0] commit_target;
    logic        flush;
    logic [31:0] redirect_pc;
    logic        wb_en;
    br_pred_t    write_back;
    logic        actual;
    logic [31:0] num_br;
    logic [31:0] num_mispred;

    br_resolve #(
        .TQ_DEPTH   (TQ_DEPTH),
        .FLUSH_HOLD (FLUSH_HOLD)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .commit_valid  (commit_valid),
        .commit_ready  (commit_ready),
        .commit_pred   (commit_pred),
        .commit_taken  (commit_taken),
        .commit_target (commit_target),
        .flush         (flush),
        .redirect_pc   (redirect_pc),
        .wb_en         (wb_en),
        .write_back    (write_back),
        .actual        (actual),
        .num_br        (num_br),
        .num_mispred   (num_mispred)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    br_train_t   m_q[$];
    int          m_block;
    logic        m_flush;
    logic [31:0] m_redirect;
    logic [31:0] m_nbr;
    logic [31:0] m_nmp;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic br_pred_t mk(input logic [31:0] pc, input logic [6:0] op,
                                    input logic [31:0] tgt, input logic tp, input logic vld);
        br_pred_t    p;
        logic [31:0] r;
        r                 = $urandom();
        p.pc              = pc;
        p.inst            = {r[31:7], op};
        p.target_pc       = tgt;
        p.gshare_index    = r[GSHARE_IDX_W-1:0];
        p.gshare_state    = r[13:12];
        p.tournament_pred = tp;
        p.valid           = vld;
        return p;
    endfunction

    function automatic logic model_mp(input br_pred_t p, input logic tk, input logic [31:0] tg);
        logic guessed;
        guessed = p.valid && ((p.inst[6:0] == OP_JAL) || (p.inst[6:0] == OP_BR && p.tournament_pred));
        if (guessed != tk) return 1'b1;
        if (tk && p.target_pc != tg) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_block    = 0;
        m_flush    = 1'b0;
        m_redirect = 32'd0;
        m_nbr      = 32'd0;
        m_nmp      = 32'd0;
    endtask

    task automatic check_outputs();
        chk("commit_ready", commit_ready, (m_block == 0 && m_q.size() < TQ_DEPTH));
        chk("flush", flush, m_flush);
        if (m_flush) chk("redirect_pc", redirect_pc, m_redirect);
        chk("wb_en", wb_en, m_q.size() != 0);
        if (m_q.size() != 0) begin
            chk("write_back", write_back, m_q[0].rec);
            chk("actual", actual, m_q[0].actual);
        end
        chk("num_br", num_br, m_nbr);
        chk("num_mispred", num_mispred, m_nmp);
    endtask

    // Called at a falling edge: check, drive the next cycle, advance the model across the rising edge.
    task automatic step(input logic v, input br_pred_t p, input logic tk,
                        input logic [31:0] tg, input logic r);
        logic      acc;
        logic      mp;
        br_train_t e;
        check_outputs();
        commit_valid  = v;
        commit_pred   = p;
        commit_taken  = tk;
        commit_target = tg;
        rst           = r;
        if (r) begin
            model_reset();
        end else begin
            acc = v && (m_block == 0) && (m_q.size() < TQ_DEPTH);
            mp  = model_mp(p, tk, tg);
            if (m_q.size() != 0) void'(m_q.pop_front());
            m_flush = acc && mp;
            if (acc && mp) begin
                m_redirect = tk ? tg : p.pc + 32'd4;
                m_block    = 1 + FLUSH_HOLD;
            end else if (m_block > 0) begin
                m_block--;
            end
            if (acc) begin
                m_nbr++;
                if (mp) m_nmp++;
                if (p.inst[6:0] == OP_BR) begin
                    e.rec    = p;
                    e.actual = tk;
                    m_q.push_back(e);
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 32'd0, 1'b0);
    endtask

    initial begin
        br_pred_t    p;
        logic [31:0] pc;
        logic [31:0] tg;
        logic        tk;
        logic [6:0]  op;

        rst           = 1'b1;
        commit_valid  = 1'b0;
        commit_pred   = '0;
        commit_taken  = 1'b0;
        commit_target = 32'd0;
        model_reset();
        repeat (2) @(negedge clk);

        chk("reset_write_back", write_back, 110'd0);
        chk("reset_actual", actual, 1'b0);
        chk("reset_redirect_pc", redirect_pc, 32'd0);

        // Correctly predicted not-taken BR
        step(1'b1, mk(32'h1000, OP_BR, 32'h2000, 1'b0, 1'b1), 1'b0, 32'h2000, 1'b0);
        chk("t1_flush", flush, 1'b0);
        chk("t1_wb_en", wb_en, 1'b1);
        chk("t1_actual", actual, 1'b0);
        chk("t1_wb_pc", write_back.pc, 32'h1000);
        chk("t1_num_br", num_br, 32'd1);
        chk("t1_num_mispred", num_mispred, 32'd0);
        idle(1);

        // Predicted taken, actually not taken
        step(1'b1, mk(32'h1000, OP_BR, 32'h2000, 1'b1, 1'b1), 1'b0, 32'h2000, 1'b0);
        chk("t2_flush", flush, 1'b1);
        chk("t2_redirect", redirect_pc, 32'h1004);
        chk("t2_ready", commit_ready, 1'b0);
        chk("t2_actual", actual, 1'b0);
        chk("t2_num_mispred", num_mispred, 32'd1);
        idle(1);
        chk("t2_ready_h1", commit_ready, 1'b0);
        idle(1);
        chk("t2_ready_h2", commit_ready, 1'b0);
        idle(1);
        chk("t2_ready_back", commit_ready, 1'b1);

        // JAL with wrong target
        step(1'b1, mk(32'h3000, OP_JAL, 32'h3100, 1'b0, 1'b1), 1'b1, 32'h3200, 1'b0);
        chk("t3_flush", flush, 1'b1);
        chk("t3_redirect", redirect_pc, 32'h3200);
        chk("t3_wb_en", wb_en, 1'b0);
        idle(FLUSH_HOLD + 1);

        // Back-to-back correct BRs
        for (int i = 0; i < 6; i++) begin
            step(1'b1, mk(32'h4000 + 32'(4 * i), OP_BR, 32'h5000, 1'b0, 1'b1), 1'b0, 32'h5000, 1'b0);
            chk("t4_ready", commit_ready, 1'b1);
            chk("t4_wb_pc", write_back.pc, 32'h4000 + 32'(4 * i));
        end
        idle(1);

        // Reset while in HOLD
        step(1'b1, mk(32'h6000, OP_BR, 32'h7000, 1'b1, 1'b1), 1'b0, 32'h7000, 1'b0);
        idle(2);
        step(1'b0, '0, 1'b0, 32'd0, 1'b1);
        chk("t5_ready", commit_ready, 1'b1);
        chk("t5_flush", flush, 1'b0);
        chk("t5_wb_en", wb_en, 1'b0);
        chk("t5_num_br", num_br, 32'd0);
        chk("t5_num_mispred", num_mispred, 32'd0);

        // Randomized commits
        for (int i = 0; i < 400; i++) begin
            pc = {$urandom_range(0, 32'h3fff_ffff), 2'b00};
            op = ($urandom_range(0, 3) == 0) ? OP_JAL : OP_BR;
            p  = mk(pc, op, ($urandom_range(0, 1) != 0) ? pc + 32'h40 : $urandom(),
                    1'($urandom_range(0, 1)), ($urandom_range(0, 9) != 0));
            tk = (op == OP_JAL) ? 1'b1 : 1'($urandom_range(0, 1));
            tg = ($urandom_range(0, 3) != 0) ? p.target_pc : $urandom();
            step(($urandom_range(0, 9) < 7), p, tk, tg, ($urandom_range(0, 99) == 0));
        end
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/br_resolve.md
# br_resolve

Commit-side branch resolution and predictor-training unit. Accepts committed branches/jumps from the ROB head together with the `br_pred_t` record produced at fetch. Compares prediction against the actual outcome, raises a one-cycle pipeline flush with a redirect PC on mispredict, and streams training updates (`wb_en`/`write_back`/`actual`) into the gshare predictor, at most one per cycle, through a small queue.

## Interface
Parameters:
- `TQ_DEPTH`, 4: training-queue entries; power of two, ≥2.
- `FLUSH_HOLD`, 2: cycles `commit_ready` stays low after a flush pulse; ≥1.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `commit_valid` in 1: ROB head is a committing BR (opcode 1100011) or JAL (1101111).
- `commit_ready` out 1: unit accepts the commit this cycle.
- `commit_pred` in `br_pred_t`: fetch-time prediction record (pc, inst, target_pc, gshare_index, gshare_state, tournament_pred, valid).
- `commit_taken` in 1: actual direction; JAL always 1.
- `commit_target` in 32: actual taken target.
- `flush` out 1: one-cycle mispredict flush.
- `redirect_pc` out 32: correct fetch PC; meaningful only while `flush`=1.
- `wb_en` out 1: predictor training write enable.
- `write_back` out `br_pred_t`: record being trained.
- `actual` out 1: outcome paired with `write_back`.
- `num_br` out 32: committed branches+jumps accepted.
- `num_mispred` out 32: mispredicts detected.

## Operation
- Accept = `commit_valid && commit_ready`.
- `commit_ready = (state==IDLE) && !tq_full`.
- Predicted-taken `pt = commit_pred.valid && ((commit_pred.tournament_pred && op==BR) || op==JAL)`, where `op = commit_pred.inst[6:0]`.
- Mispredict `mp = (pt != commit_taken) || (commit_taken && commit_pred.target_pc != commit_target)`.
- Redirect: `commit_taken ? commit_target : commit_pred.pc + 32'd4`, with 32-bit wrap.
- FSM has three states:
  - IDLE → FLUSH on an accepted commit with `mp`=1.
  - FLUSH lasts one cycle: `flush`=1 and `redirect_pc` is valid. It then goes to HOLD and loads the hold counter with `FLUSH_HOLD-1`.
  - HOLD decrements the counter each cycle. At 0 it returns to IDLE.
- Training queue:
  - On accept, an entry {commit_pred, commit_taken} is enqueued only if op==BR. JAL is never trained.
  - The queue head is presented on `write_back`/`actual`, with `wb_en` = queue non-empty. Head is popped every cycle `wb_en`=1; the predictor is always ready.
  - Enqueue and dequeue in the same cycle leave the count unchanged.
  - Full blocks accept via `commit_ready`. Empty gives `wb_en`=0.
  - Flush does not clear the queue: its entries are committed and architecturally correct.
- Counters:
  - `num_br` increments on every accept.
  - `num_mispred` increments on every accept with `mp`=1.
  - Both wrap modulo 2^32.
- Reset values:
  - state = IDLE; `flush`=0, `redirect_pc`=0.
  - Queue empty, so `wb_en`=0; `write_back`='0, `actual`=0.
  - Counters = 0.
  - Reset during FLUSH/HOLD aborts the sequence; `commit_ready`=1 on the first cycle after reset.

## Timing
- `flush`/`redirect_pc` are registered: asserted exactly the cycle after the mispredicting accept, for one cycle.
- `commit_ready` is 0 during FLUSH plus `FLUSH_HOLD` HOLD cycles, i.e. 1+`FLUSH_HOLD` cycles after the accept. It is 1 again on the following cycle if the queue is not full.
- Training latency: an entry enqueued in cycle N appears on `wb_en` no earlier than N+1. The queue is strictly FIFO in commit order, and throughput is one update per cycle.
- Counter outputs reflect an accept in cycle N from cycle N+1.
- `commit_*` inputs are ignored when not accepted.

## Structure
- Add to shared package `types`:
  - `br_res_state_e` {IDLE, FLUSH, HOLD}.
  - Opcode constants `OP_BR`=7'b1100011 and `OP_JAL`=7'b1101111, which the predictor also uses.
  - `br_train_t` = {`br_pred_t` rec; logic actual}.
- One sub-module: `train_fifo`, a synchronous FIFO of `br_train_t`. It is parameterized by depth, with full/empty flags, same-cycle push+pop, and reset-to-empty.
- Mispredict compare, FSM and counters live in `br_resolve`.

## Test plan
- BR predicted not-taken (`tournament_pred`=0), `commit_taken`=0, pc=0x1000 → no flush. Next cycle: `wb_en`=1, `actual`=0, `write_back.pc`=0x1000. `num_br`=1, `num_mispred`=0.
- BR predicted taken with target_pc=0x2000, actual not taken, pc=0x1000 → `flush`=1 next cycle with `redirect_pc`=0x1004. `commit_ready` stays low 3 cycles (`FLUSH_HOLD`=2). Training entry has `actual`=0. `num_mispred`=1.
- JAL pc=0x3000 with target_pc=0x3100 but `commit_target`=0x3200 → flush, `redirect_pc`=0x3200, and no `wb_en` ever results.
- Back-to-back correctly predicted BRs for 6 cycles → 6 consecutive `wb_en` pulses in commit order; `commit_ready` stays 1 because push and pop pair every cycle after the first.
- Force `wb_en` path stalled by injecting 4 BRs in the cycle after reset with pop shadow-checked, then fill to `TQ_DEPTH` via a test-only pop gate → `commit_ready`=0 while full; a 5th commit held with `commit_valid`=1 is accepted only after a pop.
- Assert `rst` during HOLD → next cycle state IDLE, `commit_ready`=1, `wb_en`=0, counters 0.
